// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encodings and health arithmetic.
// Latency: none; this file holds only types, constants and a pure function.
// Backpressure: not applicable.
// Contents: state_t (3-bit codes used by the LED driver and other display
// consumers), HEALTH_W, and dec_sat(), a decrement that saturates at zero.
package game_pkg;

  localparam int HEALTH_W = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_FIGHT     = 3'd2,
    S_P1_WIN    = 3'd3,
    S_P2_WIN    = 3'd4,
    S_EQ        = 3'd5
  } state_t;

  // A life is only taken when there is one left to take.
  function automatic logic [HEALTH_W-1:0] dec_sat(input logic [HEALTH_W-1:0] h,
                                                  input logic                hit);
    return (hit && (h != '0)) ? h - 1'b1 : h;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Match-controller bus: input pulses towards the sequencer, status back out.
// Latency: none; wires only.
// Backpressure: none; every signal is a pulse or a level, with no handshake.
// Ports: master drives start/p1_hit/p2_hit and reads the status buses;
//        slave (the controller) reads the pulses and drives game_state,
//        p1_health, p2_health, countdown and fight_time.
interface match_controller_if;
  import game_pkg::*;

  logic                start;
  logic                p1_hit;
  logic                p2_hit;
  logic [2:0]          game_state;
  logic [HEALTH_W-1:0] p1_health;
  logic [HEALTH_W-1:0] p2_health;
  logic [3:0]          countdown;
  logic [6:0]          fight_time;

  modport master (
    output start, p1_hit, p2_hit,
    input  game_state, p1_health, p2_health, countdown, fight_time
  );

  modport slave (
    input  start, p1_hit, p2_hit,
    output game_state, p1_health, p2_health, countdown, fight_time
  );

endinterface

// File: rtl/match_controller_sec_tick.sv
// One-second tick generator (module sec_tick) with a restartable period.
// Latency: tick is high in the CLK_HZ-th cycle after clr or rst, then every CLK_HZ cycles.
// Backpressure: none; the tick is a free-running one-cycle pulse.
// Ports: clk, rst (sync, active-high), clr (restart the period), tick (out).
module sec_tick #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  // Clearing on the edge that enters a new state makes the first cycle
  // of that state count 0, so its first tick lands exactly CLK_HZ cycles in.
  always_ff @(posedge clk) begin
    if (rst || clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/match_controller.sv
// Match sequencer: IDLE -> COUNTDOWN -> FIGHT -> result, tracking player lives.
// Latency: every output is registered; a pulse shows its effect one cycle later.
// Backpressure: none; pulses are consumed or ignored in the cycle they arrive.
// Ports: clk, rst (sync, active-high), bus (match_controller_if.slave).
// Build option: MATCH_TIMEOUT_EN adds the FIGHT time limit (fight_time counts down).
module match_controller
  import game_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int COUNTDOWN_S = 3,
  parameter int FIGHT_S     = 99,
  parameter int MAX_HEALTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  match_controller_if.slave        bus
);

  localparam logic [HEALTH_W-1:0] MAXH    = HEALTH_W'(MAX_HEALTH);
  localparam logic [3:0]          CD_LOAD = 4'(COUNTDOWN_S);

  state_t              state;
  logic [HEALTH_W-1:0] p1, p2;
  logic [HEALTH_W-1:0] p1_nxt, p2_nxt;
  logic [3:0]          cd;
  logic                tick;
  logic                leave;
  logic                ko;
  state_t              ko_res;

`ifdef MATCH_TIMEOUT_EN
  localparam logic [6:0] FT_LOAD = 7'(FIGHT_S);
  logic [6:0] ft;
  logic       time_up;
  state_t     to_res;
`endif

  sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (leave),
    .tick (tick)
  );

  always_comb begin
    p1_nxt = dec_sat(p1, bus.p1_hit);
    p2_nxt = dec_sat(p2, bus.p2_hit);
    // Results are judged on the healths after this cycle's hits.
    ko = (p1_nxt == '0) || (p2_nxt == '0);
    if ((p1_nxt == '0) && (p2_nxt == '0)) ko_res = S_EQ;
    else if (p2_nxt == '0)                ko_res = S_P1_WIN;
    else                                  ko_res = S_P2_WIN;
`ifdef MATCH_TIMEOUT_EN
    time_up = tick && (ft == 7'd1);
    if (p1_nxt > p2_nxt)      to_res = S_P1_WIN;
    else if (p2_nxt > p1_nxt) to_res = S_P2_WIN;
    else                      to_res = S_EQ;
`endif
    // leave restarts the tick period on the same edge that changes state.
    case (state)
      S_IDLE:                     leave = bus.start;
      S_COUNTDOWN:                leave = tick && (cd == 4'd1);
`ifdef MATCH_TIMEOUT_EN
      S_FIGHT:                    leave = ko || time_up;
`else
      S_FIGHT:                    leave = ko;
`endif
      S_P1_WIN, S_P2_WIN, S_EQ:   leave = bus.start;
      default:                    leave = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      p1    <= MAXH;
      p2    <= MAXH;
      cd    <= '0;
`ifdef MATCH_TIMEOUT_EN
      ft    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          p1 <= MAXH;
          p2 <= MAXH;
          if (bus.start) begin
            state <= S_COUNTDOWN;
            cd    <= CD_LOAD;
          end
        end
        S_COUNTDOWN: begin
          if (tick) begin
            if (cd == 4'd1) begin
              state <= S_FIGHT;
              cd    <= '0;
`ifdef MATCH_TIMEOUT_EN
              ft    <= FT_LOAD;
`endif
            end else begin
              cd <= cd - 1'b1;
            end
          end
        end
        S_FIGHT: begin
          p1 <= p1_nxt;
          p2 <= p2_nxt;
          // A KO outranks the time limit even on the final tick.
          if (ko) begin
            state <= ko_res;
`ifdef MATCH_TIMEOUT_EN
            ft    <= '0;
          end else if (time_up) begin
            state <= to_res;
            ft    <= '0;
          end else if (tick) begin
            ft <= ft - 1'b1;
`endif
          end
        end
        S_P1_WIN, S_P2_WIN, S_EQ: begin
          if (bus.start) begin
            state <= S_IDLE;
            p1    <= MAXH;
            p2    <= MAXH;
          end
        end
        default: begin
          state <= S_IDLE;
          p1    <= MAXH;
          p2    <= MAXH;
          cd    <= '0;
`ifdef MATCH_TIMEOUT_EN
          ft    <= '0;
`endif
        end
      endcase
    end
  end

  assign bus.game_state = state;
  assign bus.p1_health  = p1;
  assign bus.p2_health  = p2;
  assign bus.countdown  = cd;
`ifdef MATCH_TIMEOUT_EN
  assign bus.fight_time = ft;
`else
  assign bus.fight_time = '0;
`endif

endmodule

// File: doc/match_controller.md
# match_controller

Game-flow sequencer that produces the `game_state`, `p1_health` and `p2_health` buses consumed by the board LED driver and the rest of the fight logic. It takes a debounced start pulse and per-player hit pulses and walks the match through idle, countdown, fight and result states. It also tracks lives and, optionally, a fight time limit. It sits between the input-conditioning logic and every display consumer.

## Interface
- `CLK_HZ`, 50000000: clock frequency; one-second tick period in cycles.
- `COUNTDOWN_S`, 3: countdown length in seconds (1..15).
- `FIGHT_S`, 99: fight time limit in seconds (1..127); used only with the timeout feature.
- `MAX_HEALTH`, 3: starting lives per player (1..7).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle pulse, already debounced.
- `p1_hit`  in  1  one-cycle pulse: player 1 lost a life.
- `p2_hit`  in  1  one-cycle pulse: player 2 lost a life.
- `game_state`  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 P1_WIN, 4 P2_WIN, 5 EQ.
- `p1_health`  out  3  player 1 lives remaining.
- `p2_health`  out  3  player 2 lives remaining.
- `countdown`  out  4  seconds left in COUNTDOWN, 0 otherwise.
- `fight_time`  out  7  seconds left in FIGHT, 0 when the timeout feature is disabled.

## Operation
- Reset state: `game_state` is IDLE and both healths are MAX_HEALTH. `countdown`, `fight_time` and the tick counter are 0.
- IDLE
  - Healths are held at MAX_HEALTH.
  - `start` moves to COUNTDOWN and loads `countdown` with COUNTDOWN_S.
- COUNTDOWN
  - Each tick decrements `countdown`.
  - A tick seen while `countdown` is 1 moves to FIGHT, sets `countdown` to 0 and loads `fight_time` with FIGHT_S.
  - Hits and `start` are ignored.
- FIGHT
  - `p1_hit` decrements `p1_health` and `p2_hit` decrements `p2_health`. Both saturate at 0.
  - Result selection uses the post-decrement values in the same cycle:
    - p1 is 0 and p2 is 0 → EQ.
    - p2 is 0 → P1_WIN.
    - p1 is 0 → P2_WIN.
  - Simultaneous hits on both players are both applied.
  - `start` is ignored.
- Result states (P1_WIN, P2_WIN, EQ)
  - Healths are frozen and hits are ignored.
  - `start` moves to IDLE, and healths reload to MAX_HEALTH in that same cycle.
- Codes 6 and 7 are unreachable. If either is ever entered, the next cycle is IDLE.
- Health arithmetic is 3-bit unsigned. Decrement is applied only when the value is nonzero.

## Timing
- All outputs are registered. A state change is visible one cycle after the causing pulse.
- Tick
  - Fires once every CLK_HZ cycles.
  - The tick counter clears on every state entry, so the first tick after entry comes exactly CLK_HZ cycles later.
  - COUNTDOWN therefore lasts exactly COUNTDOWN_S×CLK_HZ cycles.
- Priority in one cycle: `rst` > KO result > timeout > tick decrement.
  - A hit producing a KO in the same cycle as the final tick gives the KO result.
- Reset mid-operation returns everything to reset values on the next edge, whatever the state.

## Configuration
- `MATCH_TIMEOUT_EN` defined:
  - In FIGHT, each tick decrements `fight_time`.
  - A tick seen while `fight_time` is 1 ends the fight by comparing healths:
    - higher `p1_health` → P1_WIN;
    - higher `p2_health` → P2_WIN;
    - equal → EQ.
- `MATCH_TIMEOUT_EN` undefined:
  - FIGHT ends only by KO.
  - `fight_time` is tied to 0 and no fight timer logic is built.

## Structure
- Shared package `game_pkg`:
  - state encodings S_IDLE..S_EQ (3-bit), shared with the LED driver and the other display consumers;
  - health width constant (3).
- One sub-module, `sec_tick`:
  - parameter CLK_HZ;
  - inputs `clk`, `rst`, `clr`;
  - one-cycle output `tick`.

## Test plan
Bench runs with CLK_HZ=10, COUNTDOWN_S=3, FIGHT_S=5, MAX_HEALTH=3.
- Start sequence: reset, then `start` → state 1 and `countdown`=3; state 2 exactly 30 cycles after entering COUNTDOWN, healths 3/3.
- KO: in FIGHT, three `p2_hit` pulses → `p2_health` reads 2, 1, 0; state 3 one cycle after the third hit.
- Double KO: healths 1/1, `p1_hit` and `p2_hit` in the same cycle → both healths 0, state 5.
- Ignored inputs and restart: hits during COUNTDOWN or a result state → healths unchanged; `start` in state 4 → state 0, healths 3/3.
- Timeout (MATCH_TIMEOUT_EN): healths 2/3 at the 5th tick → state 4. Same case without the macro → remains in state 2 and `fight_time`=0.
- Mid-fight reset: `rst` asserted in FIGHT with healths 1/2 → next cycle state 0, healths 3/3, `countdown` and `fight_time` 0.
